// File: rtl/instr_fetch_unit_if.sv
// ============================================================================
// Module      : instr_fetch_unit_if
// Description : Bus bundle between the instruction fetch unit and its host /
//               CPU: program-store write port, run control, instruction bus
//               and status.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface instr_fetch_unit_if #(
  parameter int AW = 4
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [20:0]   wr_data;
  logic [AW:0]   prog_len;
  logic          start;
  logic          abort;
  logic          cpu_ready;
  logic [20:0]   instruction;
  logic          instr_valid;
  logic [AW-1:0] pc;
  logic          busy;
  logic          done;

  // Host / CPU side
  modport master (
    output wr_en, wr_addr, wr_data, prog_len, start, abort, cpu_ready,
    input  instruction, instr_valid, pc, busy, done
  );

  // Fetch unit side
  modport slave (
    input  wr_en, wr_addr, wr_data, prog_len, start, abort, cpu_ready,
    output instruction, instr_valid, pc, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module      : instr_fetch_unit
// Description : Writable program store plus run/stop FSM that presents one
//               21-bit instruction word per accepted cycle to the CPU. Outside
//               a run a register-neutral NOP is driven.
//               Optional macro PROG_LOOP_EN: the last word wraps back to
//               address 0 and the run only ends on abort or reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
  parameter int          DEPTH    = 16,
  parameter int          AW       = 4,
  parameter logic [20:0] NOP_WORD = 21'h060000
) (
  input  logic                     clk,
  input  logic                     rst,
  instr_fetch_unit_if.slave        bus_if
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [AW:0]   DEPTH_W = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] ADDR0   = '0;
  localparam logic [AW:0]   ONE_W   = (AW+1)'(1);

  logic [20:0]   mem_q [DEPTH];
  state_t        state_q;
  logic [AW-1:0] pc_q;
  logic [AW:0]   len_q;
  logic [20:0]   instr_q;
  logic          valid_q;
  logic          busy_q;
  logic          done_q;

  logic          w_wr_ok;
  logic [AW:0]   w_len_start;
  logic [20:0]   w_first_word;
  logic [AW-1:0] w_pc_inc;
  logic          w_last;
  logic [20:0]   w_next_word;

  // The store is only writable while no program is running
  assign w_wr_ok      = bus_if.wr_en && (state_q != S_RUN);
  // Length is clamped to the store size so an oversize value runs DEPTH words
  assign w_len_start  = (bus_if.prog_len > DEPTH_W) ? DEPTH_W : bus_if.prog_len;
  // Write-first bypass: a same-cycle write to address 0 is what gets presented
  assign w_first_word = (w_wr_ok && (bus_if.wr_addr == ADDR0)) ? bus_if.wr_data
                                                               : mem_q[ADDR0];
  assign w_pc_inc     = pc_q + 1'b1;
  // Presented word is the last one when pc+1 reaches the latched length
  assign w_last       = (({1'b0, pc_q} + ONE_W) >= len_q);
  assign w_next_word  = mem_q[w_pc_inc];

  // Program store write port; contents deliberately survive reset
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      mem_q[bus_if.wr_addr] <= bus_if.wr_data;
    end
  end

  // Run/stop FSM with registered instruction bus and status outputs
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      instr_q <= NOP_WORD;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_RUN: begin
          if (bus_if.abort) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (bus_if.cpu_ready) begin
            if (w_last) begin
`ifdef PROG_LOOP_EN
              pc_q    <= '0;
              instr_q <= mem_q[ADDR0];
`else
              state_q <= S_DONE;
              instr_q <= NOP_WORD;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
`endif
            end else begin
              pc_q    <= w_pc_inc;
              instr_q <= w_next_word;
            end
          end
        end
        default: begin
          // IDLE and DONE behave alike; abort always wins over start
          if (bus_if.abort) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            instr_q <= NOP_WORD;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end else if (bus_if.start) begin
            len_q <= w_len_start;
            pc_q  <= '0;
            if (w_len_start == '0) begin
              state_q <= S_DONE;
              instr_q <= NOP_WORD;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_RUN;
              instr_q <= w_first_word;
              valid_q <= 1'b1;
              busy_q  <= 1'b1;
              done_q  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus_if.instruction = instr_q;
  assign bus_if.instr_valid = valid_q;
  assign bus_if.pc          = pc_q;
  assign bus_if.busy        = busy_q;
  assign bus_if.done        = done_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Directed self-checking bench for instr_fetch_unit. The
//               PROG_LOOP_EN macro selects the wrap-around sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

  localparam int          DEPTH = 16;
  localparam int          AW    = 4;
  localparam logic [20:0] NOP   = 21'h060000;
  localparam logic [20:0] W0    = 21'h000A11;
  localparam logic [20:0] W1    = 21'h020211;
  localparam logic [20:0] W2    = 21'h0C0008;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  instr_fetch_unit_if #(.AW(AW)) bus_if ();

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .AW       (AW),
    .NOP_WORD (NOP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [20:0] ins, input logic vld,
                         input logic bsy, input logic dn, input logic [AW-1:0] p);
    chk({tag, ".instruction"}, 32'(bus_if.instruction), 32'(ins));
    chk({tag, ".instr_valid"}, 32'(bus_if.instr_valid), 32'(vld));
    chk({tag, ".busy"},        32'(bus_if.busy),        32'(bsy));
    chk({tag, ".done"},        32'(bus_if.done),        32'(dn));
    chk({tag, ".pc"},          32'(bus_if.pc),          32'(p));
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [20:0] d);
    bus_if.wr_en   = 1'b1;
    bus_if.wr_addr = a;
    bus_if.wr_data = d;
    tick();
    bus_if.wr_en   = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst              = 1'b0;
    bus_if.wr_en     = 1'b0;
    bus_if.wr_addr   = '0;
    bus_if.wr_data   = '0;
    bus_if.prog_len  = '0;
    bus_if.start     = 1'b0;
    bus_if.abort     = 1'b0;
    bus_if.cpu_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk_out("reset", NOP, 1'b0, 1'b0, 1'b0, 4'd0);
    rst = 1'b1;

    // Load three words
    wr(4'd0, W0);
    wr(4'd1, W1);
    wr(4'd2, W2);
    chk_out("idle_after_wr", NOP, 1'b0, 1'b0, 1'b0, 4'd0);

`ifdef PROG_LOOP_EN
    // Wrap-around: mem0, mem1, mem0, mem1 with done low
    bus_if.prog_len  = 5'd2;
    bus_if.cpu_ready = 1'b1;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start     = 1'b0;
    chk_out("loop0", W0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_out("loop1", W1, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    chk_out("loop2", W0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_out("loop3", W1, 1'b1, 1'b1, 1'b0, 4'd1);
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    chk_out("loop_abort", NOP, 1'b0, 1'b0, 1'b0, 4'd0);

    // Zero length still completes immediately
    bus_if.prog_len = 5'd0;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    chk_out("loop_len0", NOP, 1'b0, 1'b0, 1'b1, 4'd0);
`else
    // Load and run at full rate
    bus_if.prog_len  = 5'd3;
    bus_if.cpu_ready = 1'b1;
    bus_if.start     = 1'b1;
    tick();
    bus_if.start     = 1'b0;
    chk_out("run0", W0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_out("run1", W1, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    chk_out("run2", W2, 1'b1, 1'b1, 1'b0, 4'd2);
    tick();
    chk_out("run_done", NOP, 1'b0, 1'b0, 1'b1, 4'd2);
    tick();
    chk_out("done_sticky", NOP, 1'b0, 1'b0, 1'b1, 4'd2);

    // Backpressure at pc=1 for four cycles
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    chk_out("bp0", W0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_out("bp1", W1, 1'b1, 1'b1, 1'b0, 4'd1);
    bus_if.cpu_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_out("bp_hold", W1, 1'b1, 1'b1, 1'b0, 4'd1);
    end
    bus_if.cpu_ready = 1'b1;
    tick();
    chk_out("bp2", W2, 1'b1, 1'b1, 1'b0, 4'd2);
    tick();
    chk_out("bp_done", NOP, 1'b0, 1'b0, 1'b1, 4'd2);

    // Abort beats cpu_ready at pc=1, then restart from mem[0]
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    tick();
    chk_out("ab_pc1", W1, 1'b1, 1'b1, 1'b0, 4'd1);
    bus_if.abort = 1'b1;
    tick();
    bus_if.abort = 1'b0;
    chk_out("abort", NOP, 1'b0, 1'b0, 1'b0, 4'd0);
    bus_if.start = 1'b1;
    tick();
    bus_if.start = 1'b0;
    chk_out("restart", W0, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    tick();
    tick();
    chk_out("restart_done", NOP, 1'b0, 1'b0, 1'b1, 4'd2);

    // Abort together with start in DONE: no run, done cleared
    bus_if.start = 1'b1;
    bus_if.abort = 1'b1;
    tick();
    bus_if.start = 1'b0;
    bus_if.abort = 1'b0;
    chk_out("abort_start", NOP, 1'b0, 1'b0, 1'b0, 4'd0);

    // start while running is ignored; reset mid-run
    bus_if.start = 1'b1;
    tick();
    tick();
    bus_if.start = 1'b0;
    chk_out("start_in_run", W1, 1'b1, 1'b1, 1'b0, 4'd1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk_out("midrun_reset", NOP, 1'b0, 1'b0, 1'b0, 4'd0);
    tick();
    chk_out("after_reset", NOP, 1'b0, 1'b0, 1'b0, 4'd0);

    // Zero-length program
    bus_if.prog_len = 5'd0;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    chk_out("len0", NOP, 1'b0, 1'b0, 1'b1, 4'd0);

    // Fill the whole store, then prog_len=31 clamps to 16 words
    for (int i = 0; i < DEPTH; i++) begin
      wr(AW'(i), 21'h040000 | 21'(i));
    end
    bus_if.prog_len = 5'd31;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      chk_out("len31", 21'h040000 | 21'(i), 1'b1, 1'b1, 1'b0, AW'(i));
      tick();
    end
    chk_out("len31_done", NOP, 1'b0, 1'b0, 1'b1, 4'd15);

    // Writes during RUN are dropped
    bus_if.prog_len = 5'd2;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    bus_if.wr_en    = 1'b1;
    bus_if.wr_addr  = 4'd0;
    bus_if.wr_data  = 21'h1FFFFF;
    tick();
    bus_if.wr_en    = 1'b0;
    chk_out("wr_in_run", 21'h040001, 1'b1, 1'b1, 1'b0, 4'd1);
    tick();
    bus_if.prog_len = 5'd1;
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    chk_out("rerun_mem0", 21'h040000, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    chk_out("rerun_done", NOP, 1'b0, 1'b0, 1'b1, 4'd0);

    // Write-first on address 0 in the start cycle
    bus_if.wr_en    = 1'b1;
    bus_if.wr_addr  = 4'd0;
    bus_if.wr_data  = 21'h0ABCDE;
    bus_if.start    = 1'b1;
    tick();
    bus_if.wr_en    = 1'b0;
    bus_if.start    = 1'b0;
    chk_out("wr_first", 21'h0ABCDE, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
    bus_if.start    = 1'b1;
    tick();
    bus_if.start    = 1'b0;
    chk_out("wr_first_kept", 21'h0ABCDE, 1'b1, 1'b1, 1'b0, 4'd0);
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
